// File: rtl/lsd_adc_pkg.sv
// lsd_adc_pkg: shared states, timing defaults and widths for the LSD ADC reader
package lsd_adc_pkg;
    typedef enum logic [2:0] {IDLE, WR, WAIT, RD, RECOVER} state_t;
    localparam int WR_LOW_CYC_DEF  = 8;
    localparam int RD_ACC_CYC_DEF  = 4;
    localparam int RECOVER_CYC_DEF = 6;
    localparam int TIMEOUT_CYC_DEF = 256;
    localparam int ADC_W           = 8;
    localparam int BLANK_CYC       = 2;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/lsd_adc_reader_sync2.sv
// sync2: generic two-flop synchronizer resetting to all ones
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    // two-stage capture of an asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/lsd_adc_reader.sv
// lsd_adc_reader: WR-RD mode conversion controller for the 8-bit parallel LSD ADC
module lsd_adc_reader
    import lsd_adc_pkg::*;
#(
    parameter int WR_LOW_CYC  = WR_LOW_CYC_DEF,
    parameter int RD_ACC_CYC  = RD_ACC_CYC_DEF,
    parameter int RECOVER_CYC = RECOVER_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             sample_valid,
    output logic [ADC_W-1:0] sample_data,
    output logic             sample_ofl,
    output logic             timeout_err,
    output logic             adc_cs_n,
    output logic             adc_wr_n,
    output logic             adc_rd_n,
    output logic             adc_mode,
    input  logic             adc_int_n,
    input  logic [ADC_W-1:0] adc_d,
    input  logic             adc_ofl
);
    localparam int CW = $clog2(max2(max2(WR_LOW_CYC, RD_ACC_CYC), max2(RECOVER_CYC, TIMEOUT_CYC)) + 1);
    localparam logic [CW-1:0] WR_LAST  = CW'(WR_LOW_CYC - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(RD_ACC_CYC - 1);
    localparam logic [CW-1:0] REC_LAST = CW'(RECOVER_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] BLANK    = CW'(BLANK_CYC);

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          int_s, latch, tmo;

    assign adc_mode = 1'b1;
    assign busy     = (state != IDLE);

    sync2 #(.W(1)) u_int_sync (.clk(clk), .rst(rst), .d(adc_int_n), .q(int_s));

    // state register; the counter restarts on every state change and rests at zero in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state || state == IDLE) ? '0 : cnt + CW'(1);
        end
    end

    // next state; a post-blanking interrupt takes priority over a same-cycle timeout
    always_comb begin
        state_n = state;
        latch   = 1'b0;
        tmo     = 1'b0;
        case (state)
            IDLE:    state_n = start ? WR : IDLE;
            WR:      state_n = (cnt == WR_LAST) ? WAIT : WR;
            WAIT: begin
                if (cnt >= BLANK && !int_s) begin
                    state_n = RD;
                end else if (cnt == TMO_LAST) begin
                    state_n = RECOVER;
                    tmo     = 1'b1;
                end
            end
            RD: begin
                if (cnt == RD_LAST) begin
                    state_n = RECOVER;
                    latch   = 1'b1;
                end
            end
            RECOVER: state_n = (cnt == REC_LAST) ? IDLE : RECOVER;
            default: state_n = IDLE;
        endcase
    end

    // strobes and result registers are decoded from the next state so pins never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            adc_cs_n     <= 1'b1;
            adc_wr_n     <= 1'b1;
            adc_rd_n     <= 1'b1;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
            sample_data  <= '0;
            sample_ofl   <= 1'b0;
        end else begin
            adc_cs_n     <= !(state_n == WR || state_n == WAIT || state_n == RD);
            adc_wr_n     <= (state_n != WR);
            adc_rd_n     <= (state_n != RD);
            sample_valid <= latch;
            timeout_err  <= tmo;
            if (latch) begin
                sample_data <= adc_d;
                sample_ofl  <= adc_ofl;
            end
        end
    end
endmodule

// File: tb/tb_lsd_adc_reader.sv
// tb_lsd_adc_reader: table-driven and randomized checks of the LSD ADC reader
module tb_lsd_adc_reader;
    localparam int WRC = 8, RDC = 4, RCC = 6, TMO = 256;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic       busy, sample_valid, sample_ofl, timeout_err;
    logic [7:0] sample_data;
    logic       adc_cs_n, adc_wr_n, adc_rd_n, adc_mode;
    logic       adc_int_n = 1'b1, adc_ofl = 1'b0;
    logic [7:0] adc_d = 8'h00;

    int         total = 0, bad = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_ofl = 1'b0;

    typedef struct {
        string      name;
        int         d;
        logic [7:0] data;
        logic       ofl;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    lsd_adc_reader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ofl(sample_ofl),
        .timeout_err(timeout_err), .adc_cs_n(adc_cs_n), .adc_wr_n(adc_wr_n),
        .adc_rd_n(adc_rd_n), .adc_mode(adc_mode), .adc_int_n(adc_int_n),
        .adc_d(adc_d), .adc_ofl(adc_ofl)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // int_n falls d WAIT cycles after wr_n rises (negative: already low); two sync
    // clocks plus one decision edge, never before blanking, capped by the timeout
    function automatic int exp_wait(input int d);
        int w;
        w = (d < 0) ? 3 : d + 3;
        return (w < 3) ? 3 : ((w > TMO) ? TMO : w);
    endfunction

    task automatic do_conv(input string name, input int d, input logic [7:0] data,
                           input logic ofl, input bit hold);
        int  wr = 0, wt = 0, rd = 0, rc = 0, vn = 0, vrc = -1, tn = 0, trc = -1, ovl = 0, ew;
        bit  idle = 0, to;
        logic [7:0] cd = 8'h00;
        logic       co = 1'b0;
        adc_d = data;
        adc_ofl = ofl;
        if (d < 0) adc_int_n = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 1000 && !idle; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (sample_valid) begin vn++; vrc = rc; cd = sample_data; co = sample_ofl; end
            if (timeout_err) begin tn++; trc = rc; end
            if (!adc_wr_n && !adc_rd_n) ovl++;
            if (!adc_wr_n) wr++;
            else if (!adc_rd_n) begin rd++; adc_int_n = 1'b1; end
            else if (!adc_cs_n) begin if (wt == d) adc_int_n = 1'b0; wt++; end
            else if (busy) rc++;
            else idle = 1;
        end
        adc_int_n = 1'b1;
        chk({name, " reached_idle"}, int'(idle), 1);
        ew = exp_wait(d);
        to = (d >= 0) && (d + 3 > TMO);
        chk({name, " wr_len"}, wr, WRC);
        chk({name, " wait_len"}, wt, ew);
        chk({name, " rd_len"}, rd, to ? 0 : RDC);
        chk({name, " recover_len"}, rc, RCC);
        chk({name, " overlap"}, ovl, 0);
        chk({name, " valid_cnt"}, vn, to ? 0 : 1);
        chk({name, " timeout_cnt"}, tn, to ? 1 : 0);
        if (to) chk({name, " timeout_pos"}, trc, 0);
        else begin
            chk({name, " valid_pos"}, vrc, 0);
            chk({name, " data"}, int'(cd), int'(data));
            chk({name, " ofl"}, int'(co), int'(ofl));
            last_data = data;
            last_ofl = ofl;
        end
        chk({name, " held_data"}, int'(sample_data), int'(last_data));
        chk({name, " held_ofl"}, int'(sample_ofl), int'(last_ofl));
    endtask

    initial begin
        vecs[0] = '{"normal", 20, 8'hA5, 1'b0};
        vecs[1] = '{"early_ofl", -5, 8'hFF, 1'b1};
        vecs[2] = '{"int_at_blank_end", 0, 8'h3C, 1'b0};
        vecs[3] = '{"int_ties_timeout", 253, 8'h81, 1'b1};
        vecs[4] = '{"timeout_edge", 254, 8'h11, 1'b0};
        vecs[5] = '{"timeout", 5000, 8'h22, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst cs_n", int'(adc_cs_n), 1);
        chk("rst wr_n", int'(adc_wr_n), 1);
        chk("rst rd_n", int'(adc_rd_n), 1);
        chk("rst mode", int'(adc_mode), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst valid", int'(sample_valid), 0);
        chk("rst tmo", int'(timeout_err), 0);
        chk("rst data", int'(sample_data), 0);
        chk("rst ofl", int'(sample_ofl), 0);

        foreach (vecs[i]) do_conv(vecs[i].name, vecs[i].d, vecs[i].data, vecs[i].ofl, 1'b0);

        do_conv("b2b_first", 10, 8'h00, 1'b0, 1'b1);
        do_conv("b2b_second", 10, 8'hFF, 1'b0, 1'b1);
        start = 1'b0;

        for (int i = 0; i < 12; i++) begin
            int d;
            d = ($urandom_range(0, 4) == 0) ? -int'($urandom_range(1, 6)) : int'($urandom_range(0, 40));
            do_conv("random", d, 8'($urandom), 1'($urandom), 1'b0);
        end

        begin
            bit seen = 0;
            int vn = 0;
            adc_d = 8'h5A;
            adc_int_n = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clk);
                seen = !adc_rd_n;
            end
            chk("rstrd reached_rd", int'(seen), 1);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            adc_int_n = 1'b1;
            chk("rstrd rd_n", int'(adc_rd_n), 1);
            chk("rstrd cs_n", int'(adc_cs_n), 1);
            chk("rstrd busy", int'(busy), 0);
            chk("rstrd data", int'(sample_data), 0);
            repeat (10) begin
                if (sample_valid) vn++;
                @(negedge clk);
            end
            chk("rstrd no_valid", vn, 0);
            chk("rstrd idle", int'(busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsd_adc_reader.md
# lsd_adc_reader

Controller for the 8-bit parallel LSD ADC (ADC0820-class, WR-RD mode) on the UP5K. It issues the conversion-start strobe and waits for the ADC's end-of-conversion interrupt. It then performs the read cycle that drives data onto d7..d0/ofl and returns each result as a one-cycle sample on the fabric side. The ADC is the writer on the shared bus and this block is its reader. It sits between the top-level `lsd_adc_*` pins and the downstream measurement logic.

## Interface
- `WR_LOW_CYC`, default 8: clocks `adc_wr_n` is held low to start a conversion (≥1).
- `RD_ACC_CYC`, default 4: clocks `adc_rd_n` is low before data is latched (≥1).
- `RECOVER_CYC`, default 6: idle clocks after a read or timeout before the next start (≥1).
- `TIMEOUT_CYC`, default 256: maximum clocks spent waiting for `adc_int_n` after `wr_n` release.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request one conversion; sampled only in IDLE.
- `busy` out 1: high whenever state ≠ IDLE.
- `sample_valid` out 1: one-cycle pulse; the result is valid.
- `sample_data` out 8: last converted code, held until the next valid.
- `sample_ofl` out 1: overflow bit captured with `sample_data`.
- `timeout_err` out 1: one-cycle pulse when a conversion times out.
- `adc_cs_n` out 1: ADC chip select, active-low.
- `adc_wr_n` out 1: ADC WR/RDY pin, driven as the start strobe, active-low.
- `adc_rd_n` out 1: ADC read strobe, active-low.
- `adc_mode` out 1: tied to 1 (WR-RD mode).
- `adc_int_n` in 1: end-of-conversion, active-low, asynchronous.
- `adc_d` in 8: ADC data bus (d7 = MSB).
- `adc_ofl` in 1: ADC overflow output.

## Operation
- **Reset values:** `adc_cs_n`=1, `adc_wr_n`=1, `adc_rd_n`=1, `adc_mode`=1, `busy`=0, `sample_valid`=0, `timeout_err`=0, `sample_data`=0, `sample_ofl`=0, state=IDLE, all counters=0.
- **Synchronizer:** `adc_int_n` passes through a 2-flop synchronizer, giving `int_s`. `adc_d` and `adc_ofl` are not synchronized; they are stable while `rd_n` is low once RD_ACC_CYC has elapsed.
- **IDLE:** if `start`=1, go to WR. Otherwise stay.
- **WR:** `cs_n`=0 and `wr_n`=0 for exactly WR_LOW_CYC cycles, then go to WAIT.
- **WAIT:** `cs_n`=0, `wr_n`=1.
  - The first 2 cycles are blanking; `int_s` is ignored during them.
  - After blanking, `int_s`=0 sends the block to RD.
  - If the counter reaches TIMEOUT_CYC (counted from WAIT entry), go to RECOVER, pulse `timeout_err`, and set `cs_n`=1.
  - If both conditions hold in the same cycle, the interrupt wins.
- **RD:** `cs_n`=0, `rd_n`=0 for RD_ACC_CYC cycles. On the last cycle, latch `adc_d` and `adc_ofl`. Then go to RECOVER.
- **RECOVER:** `cs_n`=`rd_n`=`wr_n`=1 for RECOVER_CYC cycles, then go to IDLE.
- `start` outside IDLE is ignored; there is no queuing.
- A single shared down/up counter is sized to `$clog2(max(parameters)+1)` bits. It never wraps: it reloads on every state entry.
- `rst` asserted in any state returns all outputs to their reset values on the next edge, including mid-strobe (strobes deassert immediately). Any partially read sample is discarded.

## Timing
- `start` high at edge k puts `wr_n`=0 and `cs_n`=0 from k+1 through k+WR_LOW_CYC.
- `adc_int_n` falls asynchronously. `int_s` is low 2–3 clocks later, and `rd_n` goes low on the following edge.
- `sample_valid` is high in the first RECOVER cycle. `sample_data` updates on that same edge.
- Minimum start-to-start period = WR_LOW_CYC + 2 + 1 + RD_ACC_CYC + RECOVER_CYC + sync latency.
- `busy` falls on the edge entering IDLE. `start` may be high in that same cycle and is accepted at the next edge.

## Structure
- Shared package `lsd_adc_pkg` holds:
  - the state enum (IDLE, WR, WAIT, RD, RECOVER);
  - default timing constants;
  - the ADC data width (8).
- Sub-module `sync2`: a generic 2-flop synchronizer with reset value 1, used for `adc_int_n` and reusable for `gps_pps*`.

## Test plan
- **Normal conversion:** reset, pulse `start`; model asserts `int_n` low 20 clk after `wr_n` rises and drives d=0xA5, ofl=0. Required: `wr_n` low for exactly 8 clk, `rd_n` low for 4 clk, one `sample_valid` with `sample_data`=0xA5, `sample_ofl`=0, `busy` low 6 clk later.
- **Timeout:** `int_n` never asserts. Required: `timeout_err` pulse 256 clk after WAIT entry, `cs_n`=1, no `sample_valid`, return to IDLE.
- **Start while busy:** `start` held high continuously with d=0x00 then 0xFF. Required: back-to-back conversions separated by ≥RECOVER_CYC idle strobes, samples 0x00 then 0xFF, no overlap of `wr_n`/`rd_n`.
- **Reset mid-read:** assert `rst` on the 2nd RD cycle. Required: `rd_n`=`cs_n`=1 next clk, no `sample_valid`, `sample_data`=0.
- **Overflow and early int:** `int_n` low already during blanking, d=0xFF, ofl=1. Required: read begins only after blanking, `sample_ofl`=1, `sample_data`=0xFF.
